piso_serializer: RTL and testbench

Parallel-in, serial-out transmitter: accepts a WIDTH-bit word over a load/ready handshake and shifts it out one bit per clock with a frame-valid qualifier. It is the transmit end of our 4-bit register datapath. It turns a parallel word, such as one held in the PIPO register, into a serial stream for a downstream SIPO receiver. It supports back-to-back words with no idle gap.

---
 rtl/piso_pkg.sv | 33 +++
 rtl/piso_bit_counter.sv | 46 ++++
 rtl/piso_serializer.sv | 153 +++++++++++++++
 tb/tb_piso_serializer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// -----------------------------------------------------------------------------
// piso_pkg
// Shared definitions for the piso_serializer transmitter.
//   - state_t     : serializer FSM states (IDLE, SHIFT)
//   - cnt_width() : width of the bit counter for a given data width
//   - even_parity(): parity of a captured word (only when PISO_PARITY_EN is
//                    defined)
// Configuration macro: PISO_PARITY_EN (appends one even-parity bit per frame).
// -----------------------------------------------------------------------------
package piso_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Counter must reach FRAME_LEN-1, which is at most WIDTH; WIDTH+2 keeps
   // one spare code so the width never collapses for small words.
   function automatic int cnt_width(input int width);
      return $clog2(width + 2);
   endfunction

`ifdef PISO_PARITY_EN
   // Words are zero-extended into this container; zero-extension does not
   // change the XOR reduction.
   localparam int PARITY_MAX_W = 64;

   function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] word);
      return ^word;
   endfunction
`endif

endpackage

// File: rtl/piso_bit_counter.sv
// -----------------------------------------------------------------------------
// piso_bit_counter
// Loadable up-counter that tracks which bit of the frame is on serial_out.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-low clear (count -> 0)
//   load       in   load load_value (has priority over inc)
//   load_value in   value loaded when load is high
//   inc        in   increment by one
//   count      out  current count
//   terminal   out  high while count == TERMINAL (the last-bit flag)
// -----------------------------------------------------------------------------
module piso_bit_counter
   import piso_pkg::*;
#(
   parameter int CNT_W    = 3,
   parameter int TERMINAL = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_value,
   input  logic             inc,
   output logic [CNT_W-1:0] count,
   output logic             terminal
);

   localparam logic [CNT_W-1:0] TERM_VAL = CNT_W'(TERMINAL);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   logic [CNT_W-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (!reset) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_value;
      end else if (inc) begin
         count_reg <= count_reg + ONE;
      end
   end

   assign count    = count_reg;
   assign terminal = (count_reg == TERM_VAL);

endmodule

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
// Parallel-in / serial-out transmitter. A WIDTH-bit word is accepted on a
// load/ready handshake and shifted out one bit per clock, qualified by frame.
// A new word may be accepted in the last-bit cycle, giving a gap-free stream.
//
// Parameters:
//   WIDTH     data word width (>= 2)
//   MSB_FIRST 1: data_in[WIDTH-1] goes first, 0: data_in[0] goes first
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-low reset
//   load       in   word valid, accepted when load && ready at a rising edge
//   data_in    in   parallel word, sampled only on the accepting edge
//   ready      out  can accept a word this cycle (combinational)
//   serial_out out  serial data bit (registered, 0 outside a frame)
//   frame      out  serial_out carries a valid bit (registered)
//   done       out  one-cycle pulse with the last bit of a frame (combinational)
// Configuration macro: PISO_PARITY_EN -- when defined, an even-parity bit over
// the captured word follows the data bits and the frame is WIDTH+1 long.
// -----------------------------------------------------------------------------
module piso_serializer
   import piso_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] data_in,
   output logic             ready,
   output logic             serial_out,
   output logic             frame,
   output logic             done
);

`ifdef PISO_PARITY_EN
   localparam int FRAME_LEN = WIDTH + 1;
`else
   localparam int FRAME_LEN = WIDTH;
`endif
   localparam int CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_DATA_CNT = CNT_W'(WIDTH - 1);

   state_t           state_reg;
   logic [WIDTH-1:0] shift_reg;
   logic             serial_reg;
   logic             frame_reg;
   // Set at the first edge that samples reset high; keeps ready low for the
   // cycle in which reset is released but no edge has yet seen it.
   logic             armed_reg;

   logic [WIDTH-1:0] data_ordered;
   logic [CNT_W-1:0] bit_cnt;
   logic             cnt_terminal;
   logic             cnt_load;
   logic             cnt_inc;
   logic             last_bit;
   logic             accept;
   logic             data_phase;
   logic             tail_bit;

   // Present the word in transmit order so the shifter always shifts left
   // and always takes its output from the top bit.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_order
         if (MSB_FIRST) begin : g_msb
            assign data_ordered[gi] = data_in[gi];
         end else begin : g_lsb
            assign data_ordered[gi] = data_in[WIDTH-1-gi];
         end
      end
   endgenerate

   assign last_bit = (state_reg == SHIFT) && cnt_terminal;
   assign ready    = reset && armed_reg && ((state_reg == IDLE) || last_bit);
   assign done     = reset && last_bit;
   assign accept   = load && ready;

   // bit_cnt holds the index of the bit currently on serial_out. While it is
   // below WIDTH-1 another data bit is still waiting in the shift register.
   assign data_phase = (bit_cnt < LAST_DATA_CNT);

   // Counter restarts at 0 on every accepted word and on leaving SHIFT.
   assign cnt_load = accept || last_bit;
   assign cnt_inc  = (state_reg == SHIFT) && !cnt_terminal;

   piso_bit_counter #(
      .CNT_W    (CNT_W),
      .TERMINAL (FRAME_LEN - 1)
   ) u_bit_counter (
      .clk        (clk),
      .reset      (reset),
      .load       (cnt_load),
      .load_value ('0),
      .inc        (cnt_inc),
      .count      (bit_cnt),
      .terminal   (cnt_terminal)
   );

`ifdef PISO_PARITY_EN
   logic parity_reg;

   always_ff @(posedge clk) begin
      if (!reset) begin
         parity_reg <= 1'b0;
      end else if (accept) begin
         parity_reg <= even_parity(PARITY_MAX_W'(data_in));
      end
   end

   assign tail_bit = parity_reg;
`else
   // Without parity the bit after the data is never reached inside a frame.
   assign tail_bit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg  <= IDLE;
         shift_reg  <= '0;
         serial_reg <= 1'b0;
         frame_reg  <= 1'b0;
         armed_reg  <= 1'b0;
      end else begin
         armed_reg <= 1'b1;
         if (accept) begin
            // First bit goes straight to the output register; the shifter
            // keeps the remaining bits, already advanced by one position.
            state_reg  <= SHIFT;
            shift_reg  <= {data_ordered[WIDTH-2:0], 1'b0};
            serial_reg <= data_ordered[WIDTH-1];
            frame_reg  <= 1'b1;
         end else if (state_reg == SHIFT) begin
            if (last_bit) begin
               state_reg  <= IDLE;
               shift_reg  <= '0;
               serial_reg <= 1'b0;
               frame_reg  <= 1'b0;
            end else begin
               serial_reg <= data_phase ? shift_reg[WIDTH-1] : tail_bit;
               shift_reg  <= {shift_reg[WIDTH-2:0], 1'b0};
            end
         end
      end
   end

   assign serial_out = serial_reg;
   assign frame      = frame_reg;

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
// Two instances with WIDTH=4: lane 0 MSB-first, lane 1 LSB-first. Every
// accepted word pushes its expected bit stream into a per-lane queue; the
// negedge monitor pops one entry for every frame cycle and compares the bit
// and the done flag. Directed steps check ready, frame and reset behaviour.
// Honours PISO_PARITY_EN for the expected frame length and parity bit.
// -----------------------------------------------------------------------------
module tb_piso_serializer;

   localparam int W = 4;
`ifdef PISO_PARITY_EN
   localparam int FRAME_LEN = W + 1;
`else
   localparam int FRAME_LEN = W;
`endif

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         load_a = 1'b0;
   logic         load_b = 1'b0;
   logic [W-1:0] data_a = '0;
   logic [W-1:0] data_b = '0;
   logic         ready_a, serial_a, frame_a, done_a;
   logic         ready_b, serial_b, frame_b, done_b;

   always #5 clk = ~clk;

   piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_a (
      .clk        (clk),
      .reset      (reset),
      .load       (load_a),
      .data_in    (data_a),
      .ready      (ready_a),
      .serial_out (serial_a),
      .frame      (frame_a),
      .done       (done_a)
   );

   piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_b (
      .clk        (clk),
      .reset      (reset),
      .load       (load_b),
      .data_in    (data_b),
      .ready      (ready_b),
      .serial_out (serial_b),
      .frame      (frame_b),
      .done       (done_b)
   );

   typedef struct packed {
      logic b;
      logic last;
   } sb_entry_t;

   sb_entry_t q_a[$];
   sb_entry_t q_b[$];
   int checks = 0;
   int failures = 0;
   int frame_cycles[2] = '{0, 0};
   int done_pulses[2] = '{0, 0};

   task automatic check_value(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, observed, expected, $time);
      end
   endtask

   task automatic push_word(input int lane, input logic [W-1:0] w, input bit msb_first);
      sb_entry_t e;
      logic par;
      par = ^w;
      $display("word lane=%0d data=%b accepted t=%0t", lane, w, $time);
      for (int i = 0; i < FRAME_LEN; i++) begin
         if (i < W) e.b = msb_first ? w[W-1-i] : w[i];
         else       e.b = par;
         e.last = (i == FRAME_LEN - 1);
         if (lane == 0) q_a.push_back(e);
         else           q_b.push_back(e);
      end
   endtask

   // Scoreboard feed: handshake seen at the accepting edge; reset discards.
   always @(posedge clk) begin
      if (!reset) begin
         q_a.delete();
         q_b.delete();
      end else begin
         if (load_a && ready_a) push_word(0, data_a, 1'b1);
         if (load_b && ready_b) push_word(1, data_b, 1'b0);
      end
   end

   task automatic monitor_lane(input int lane, input logic frm, input logic ser,
                               input logic dn);
      sb_entry_t e;
      bit have;
      have = 1'b0;
      e = '0;
      if (frm) begin
         frame_cycles[lane]++;
         if (lane == 0 && q_a.size() > 0) begin
            e = q_a.pop_front();
            have = 1'b1;
         end else if (lane == 1 && q_b.size() > 0) begin
            e = q_b.pop_front();
            have = 1'b1;
         end
         if (!have) begin
            check_value($sformatf("unexpected_frame[%0d]", lane), frm, 0);
         end else begin
            check_value($sformatf("serial_bit[%0d]", lane), ser, e.b);
            check_value($sformatf("done_on_last[%0d]", lane), dn, e.last);
         end
      end else begin
         check_value($sformatf("idle_serial_low[%0d]", lane), ser, 0);
         check_value($sformatf("idle_no_done[%0d]", lane), dn, 0);
      end
      if (dn) done_pulses[lane]++;
   endtask

   always @(negedge clk) begin
      monitor_lane(0, frame_a, serial_a, done_a);
      monitor_lane(1, frame_b, serial_b, done_b);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int fc;
   int dp;

   initial begin
      // Reset held low for two edges
      reset = 1'b0;
      step();
      step();
      check_value("rst_ready_a", ready_a, 0);
      check_value("rst_ready_b", ready_b, 0);
      check_value("rst_frame_a", frame_a, 0);
      check_value("rst_serial_a", serial_a, 0);
      check_value("rst_done_a", done_a, 0);
      reset = 1'b1;
      #1;
      check_value("ready_before_first_edge", ready_a, 0);
      step();
      check_value("ready_after_release_a", ready_a, 1);
      check_value("ready_after_release_b", ready_b, 1);

      // Basic MSB-first word 1010
      fc = frame_cycles[0];
      dp = done_pulses[0];
      data_a = 4'b1010;
      load_a = 1'b1;
      step();
      load_a = 1'b0;
      check_value("basic_first_bit", serial_a, 1);
      check_value("basic_busy_ready", ready_a, 0);
      repeat (FRAME_LEN - 1) step();
      check_value("basic_last_done", done_a, 1);
      check_value("basic_last_ready", ready_a, 1);
      step();
      check_value("basic_frame_drop", frame_a, 0);
      check_value("basic_frame_len", frame_cycles[0] - fc, FRAME_LEN);
      check_value("basic_done_count", done_pulses[0] - dp, 1);

      // LSB-first word 0001
      fc = frame_cycles[1];
      dp = done_pulses[1];
      data_b = 4'b0001;
      load_b = 1'b1;
      step();
      load_b = 1'b0;
      check_value("lsb_first_bit", serial_b, 1);
      repeat (FRAME_LEN - 1) step();
      check_value("lsb_last_done", done_b, 1);
      step();
      check_value("lsb_frame_len", frame_cycles[1] - fc, FRAME_LEN);
      check_value("lsb_done_count", done_pulses[1] - dp, 1);

      // Back-to-back: 1010 then 1111 on the last-bit cycle
      fc = frame_cycles[0];
      dp = done_pulses[0];
      data_a = 4'b1010;
      load_a = 1'b1;
      step();
      data_a = 4'b1111;
      for (int i = 1; i < FRAME_LEN; i++) begin
         check_value("b2b_frame_w1", frame_a, 1);
         step();
      end
      check_value("b2b_ready_last", ready_a, 1);
      step();
      load_a = 1'b0;
      for (int i = 1; i < FRAME_LEN; i++) begin
         check_value("b2b_frame_w2", frame_a, 1);
         step();
      end
      check_value("b2b_done_w2", done_a, 1);
      step();
      check_value("b2b_frame_drop", frame_a, 0);
      check_value("b2b_frame_len", frame_cycles[0] - fc, 2 * FRAME_LEN);
      check_value("b2b_done_count", done_pulses[0] - dp, 2);

      // Busy ignore: 1100, then a load pulse of 0011 in bit cycle 2
      fc = frame_cycles[0];
      data_a = 4'b1100;
      load_a = 1'b1;
      step();
      load_a = 1'b0;
      check_value("busy_ready_c1", ready_a, 0);
      step();
      check_value("busy_ready_c2", ready_a, 0);
      data_a = 4'b0011;
      load_a = 1'b1;
      step();
      load_a = 1'b0;
      check_value("busy_ready_c3", ready_a, 0);
      repeat (FRAME_LEN - 3) step();
      check_value("busy_ready_last", ready_a, 1);
      step();
      step();
      check_value("busy_no_second_frame", frame_a, 0);
      check_value("busy_frame_len", frame_cycles[0] - fc, FRAME_LEN);

      // Reset in bit cycle 2 of 1111
      data_a = 4'b1111;
      load_a = 1'b1;
      step();
      load_a = 1'b0;
      step();
      dp = done_pulses[0];
      reset = 1'b0;
      step();
      check_value("midrst_frame", frame_a, 0);
      check_value("midrst_serial", serial_a, 0);
      check_value("midrst_done", done_a, 0);
      check_value("midrst_ready", ready_a, 0);
      reset = 1'b1;
      #1;
      check_value("midrst_ready_release", ready_a, 0);
      step();
      check_value("midrst_ready_after", ready_a, 1);
      check_value("midrst_no_done", done_pulses[0] - dp, 0);
      fc = frame_cycles[0];
      dp = done_pulses[0];
      data_a = 4'b0101;
      load_a = 1'b1;
      step();
      load_a = 1'b0;
      check_value("post_rst_first_bit", serial_a, 0);
      repeat (FRAME_LEN) step();
      check_value("post_rst_frame_len", frame_cycles[0] - fc, FRAME_LEN);
      check_value("post_rst_done_count", done_pulses[0] - dp, 1);

      // 1011: odd weight, so the parity bit (when enabled) is 1
      fc = frame_cycles[0];
      dp = done_pulses[0];
      data_a = 4'b1011;
      load_a = 1'b1;
      step();
      load_a = 1'b0;
      repeat (FRAME_LEN - 1) step();
      check_value("w1011_last_done", done_a, 1);
      check_value("w1011_last_serial", serial_a, (FRAME_LEN > W) ? 1 : 1);
      step();
      check_value("w1011_frame_len", frame_cycles[0] - fc, FRAME_LEN);
      check_value("w1011_done_count", done_pulses[0] - dp, 1);

      step();
      check_value("sb_drained_a", q_a.size(), 0);
      check_value("sb_drained_b", q_b.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
